// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin arbiter that lets N_MASTER Wishbone masters share one slave.
// An owner is picked in IDLE (search starts one past the previous owner),
// registered into grant_o, and its request is then routed combinationally to
// the slave until it drops cyc. Every ownership change passes through at
// least one IDLE cycle.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN):
//   A stall counter watches BUSY cycles with the strobe up and no ack/err.
//   On reaching TIMEOUT_CYCLES the arbiter drops the slave cycle, pulses the
//   owner's m_err_o for one cycle (ABORT) and then waits in RELEASE for the
//   owner to drop cyc. Without the macro there is no counter and a stalled
//   slave keeps the grant indefinitely.
//
// Ports:
//   clk, rstn_i              clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i          per-master address / write data, 32 bits each,
//                            master k at [32k+31:32k]
//   m_sel_i                  per-master byte selects, 4 bits each
//   m_ack_o/m_err_o          per-master acknowledge / error
//   m_dat_o                  read data, broadcast (always s_dat_i)
//   s_*_o                    shared slave request
//   s_ack_i/s_err_i/s_dat_i  slave response
//   grant_o                  one-hot owner, zero when idle
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int N_MASTER       = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rstn_i,
   input  logic [N_MASTER-1:0]      m_cyc_i,
   input  logic [N_MASTER-1:0]      m_stb_i,
   input  logic [N_MASTER-1:0]      m_we_i,
   input  logic [32*N_MASTER-1:0]   m_adr_i,
   input  logic [32*N_MASTER-1:0]   m_dat_i,
   input  logic [4*N_MASTER-1:0]    m_sel_i,
   output logic [N_MASTER-1:0]      m_ack_o,
   output logic [N_MASTER-1:0]      m_err_o,
   output logic [31:0]              m_dat_o,
   output logic                     s_cyc_o,
   output logic                     s_stb_o,
   output logic                     s_we_o,
   output logic [31:0]              s_adr_o,
   output logic [31:0]              s_dat_o,
   output logic [3:0]               s_sel_o,
   input  logic                     s_ack_i,
   input  logic                     s_err_i,
   input  logic [31:0]              s_dat_i,
   output logic [N_MASTER-1:0]      grant_o
);

   localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_ABORT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t              r_state;
   logic [N_MASTER-1:0] r_grant;
   logic [IW-1:0]       r_gidx;
   logic [IW-1:0]       r_last;

   // Routed request of the current owner (all zero when nobody owns the bus)
   logic                w_cyc;
   logic                w_stb;
   logic                w_we;
   logic [31:0]         w_adr;
   logic [31:0]         w_dat;
   logic [3:0]          w_sel;

   // Next-owner search
   logic                w_any;
   logic                w_hi_vld;
   logic [IW-1:0]       w_hi_idx;
   logic [IW-1:0]       w_lo_idx;
   logic [IW-1:0]       w_nidx;
   logic [N_MASTER-1:0] w_ngrant;

   logic                w_busy;
   logic                w_abort;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       r_tmo;
`else
   logic                w_unused_tmo_cfg;
   assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // -------------------------------------------------------------------------
   // Owner mux: r_grant is one-hot or zero, so at most one iteration hits.
   // -------------------------------------------------------------------------
   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      for (int m = 0; m < N_MASTER; m++) begin
         if (r_grant[m]) begin
            w_cyc = m_cyc_i[m];
            w_stb = m_stb_i[m];
            w_we  = m_we_i[m];
            w_adr = m_adr_i[m*32 +: 32];
            w_dat = m_dat_i[m*32 +: 32];
            w_sel = m_sel_i[m*4 +: 4];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Round-robin search. The lowest requester strictly above r_last wins;
   // if there is none, the lowest requester at or below r_last wraps around.
   // Scanning downward lets the last hit be the lowest index.
   // -------------------------------------------------------------------------
   always_comb begin
      w_hi_vld = 1'b0;
      w_hi_idx = '0;
      w_lo_idx = '0;
      for (int m = N_MASTER-1; m >= 0; m--) begin
         if (m_cyc_i[m]) begin
            if (m > int'(r_last)) begin
               w_hi_vld = 1'b1;
               w_hi_idx = IW'(m);
            end else begin
               w_lo_idx = IW'(m);
            end
         end
      end
   end

   assign w_any    = |m_cyc_i;
   assign w_nidx   = w_hi_vld ? w_hi_idx : w_lo_idx;
   assign w_ngrant = N_MASTER'(1) << w_nidx;

   // -------------------------------------------------------------------------
   // State machine
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(N_MASTER-1);
`ifdef WB_ARB_TIMEOUT_EN
         r_tmo   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_ngrant;
                  r_gidx  <= w_nidx;
                  r_state <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (!w_cyc) begin
                  // Owner released (an ack in this same cycle is still
                  // delivered by the combinational response path).
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_last  <= r_gidx;
`ifdef WB_ARB_TIMEOUT_EN
                  r_tmo   <= '0;
               end else if (s_ack_i || s_err_i) begin
                  r_tmo   <= '0;
               end else if (w_stb) begin
                  if (r_tmo == TW'(TIMEOUT_CYCLES-1)) begin
                     r_state <= ST_ABORT;
                  end
                  r_tmo <= r_tmo + 1'b1;
`endif
               end
            end

`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
               r_state <= ST_RELEASE;
               r_tmo   <= '0;
            end

            ST_RELEASE: begin
               // Grant is held so no one else sees the half-aborted slave
               // until the offending master lets go.
               if (!w_cyc) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_last  <= r_gidx;
               end
            end
`endif

            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. The slave only sees a cycle while BUSY; ABORT/RELEASE and IDLE
   // keep it quiet. Reset forces r_state to IDLE asynchronously, which drops
   // s_cyc_o at once.
   // -------------------------------------------------------------------------
   assign w_busy  = (r_state == ST_BUSY);
   assign w_abort = (r_state == ST_ABORT);

   assign s_cyc_o = w_busy & w_cyc;
   assign s_stb_o = w_busy & w_stb;
   assign s_we_o  = w_busy & w_we;
   assign s_adr_o = w_busy ? w_adr : '0;
   assign s_dat_o = w_busy ? w_dat : '0;
   assign s_sel_o = w_busy ? w_sel : '0;

   assign m_ack_o = w_busy ? (r_grant & {N_MASTER{s_ack_i}}) : '0;
   assign m_err_o = w_busy  ? (r_grant & {N_MASTER{s_err_i}}) :
                    w_abort ? r_grant : '0;

   assign m_dat_o = s_dat_i;
   assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

   localparam int N = 4;

   logic          clk;
   logic          rstn;
   logic [N-1:0]  m_cyc, m_stb, m_we;
   logic [32*N-1:0] m_adr, m_dat;
   logic [4*N-1:0]  m_sel;
   logic [N-1:0]  m_ack, m_err;
   logic [31:0]   m_dat_o;
   logic          s_cyc, s_stb, s_we;
   logic [31:0]   s_adr, s_dat_o;
   logic [3:0]    s_sel;
   logic          s_ack, s_err;
   logic [31:0]   s_dat_i;
   logic [N-1:0]  grant;

   int n_cmp = 0;
   int n_bad = 0;

   wb_rr_arbiter #(.N_MASTER(N), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rstn_i(rstn),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
      .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat_i),
      .grant_o(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] cyc;
      logic         ack;
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_ack;
      logic         exp_scyc;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic [N-1:0] c, input logic a, input logic [N-1:0] g,
                      input logic [N-1:0] k, input logic s);
      vec_t v;
      v.cyc = c; v.ack = a; v.exp_grant = g; v.exp_ack = k; v.exp_scyc = s;
      tbl.push_back(v);
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0;
      s_ack = 1'b0; s_err = 1'b0;
      tick();
      chk("rst_grant", grant, 0);
      chk("rst_scyc", s_cyc, 0);
      chk("rst_sstb", s_stb, 0);
      chk("rst_mack", m_ack, 0);
      chk("rst_merr", m_err, 0);
      tick();
      rstn = 1'b1;
   endtask

   // Reference: next owner is the first requester after 'last', modulo N.
   function automatic int next_owner(input int last, input logic [N-1:0] cyc);
      for (int d = 1; d <= N; d++) begin
         if (cyc[(last + d) % N]) return (last + d) % N;
      end
      return -1;
   endfunction

   int owner, last, acked_m, since;
   logic [31:0] exp_w;

   initial begin
      rstn = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_adr = '0; m_dat = '0; m_sel = '0;
      s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;
      #1;
      chk("rst0_scyc", s_cyc, 0);
      chk("rst0_grant", grant, 0);

      // ---- table: first grant / second owner, then 0,1,2,3,0 rotation ----
      add(4'b1010, 0, 4'b0000, 4'b0000, 0);
      add(4'b1010, 1, 4'b0010, 4'b0010, 1);
      add(4'b1000, 0, 4'b0010, 4'b0000, 0);
      add(4'b1000, 0, 4'b0000, 4'b0000, 0);
      add(4'b1000, 1, 4'b1000, 4'b1000, 1);
      add(4'b0000, 0, 4'b1000, 4'b0000, 0);
      add(4'b0000, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 1, 4'b0001, 4'b0001, 1);
      add(4'b1110, 0, 4'b0001, 4'b0000, 0);
      add(4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 1, 4'b0010, 4'b0010, 1);
      add(4'b1101, 0, 4'b0010, 4'b0000, 0);
      add(4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 1, 4'b0100, 4'b0100, 1);
      add(4'b1011, 0, 4'b0100, 4'b0000, 0);
      add(4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 1, 4'b1000, 4'b1000, 1);
      add(4'b0111, 0, 4'b1000, 4'b0000, 0);
      add(4'b1111, 0, 4'b0000, 4'b0000, 0);
      add(4'b1111, 1, 4'b0001, 4'b0001, 1);
      add(4'b1110, 0, 4'b0001, 4'b0000, 0);
      add(4'b0000, 0, 4'b0000, 4'b0000, 0);

      do_reset();
      foreach (tbl[i]) begin
         m_cyc = tbl[i].cyc; m_stb = tbl[i].cyc; s_ack = tbl[i].ack;
         #1;
         chk($sformatf("tbl%0d_grant", i), grant, tbl[i].exp_grant);
         chk($sformatf("tbl%0d_mack", i), m_ack, tbl[i].exp_ack);
         chk($sformatf("tbl%0d_scyc", i), s_cyc, tbl[i].exp_scyc);
         tick();
      end
      s_ack = 1'b0;

      // ---- ack in the same cycle the owner drops cyc ----
      m_cyc = 4'b0010; m_stb = 4'b0010;            // master1 first, so last=1
      tick();
      chk("pre_grant1", grant, 4'b0010);
      m_cyc = '0; m_stb = '0; s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      m_adr[2*32 +: 32] = 32'h1000_0004; m_we = '0; m_sel[2*4 +: 4] = 4'hF;
      m_adr[0 +: 32] = 32'h0000_0100;
      m_cyc = 4'b0101; m_stb = 4'b0101;
      tick();
      chk("rd_grant", grant, 4'b0100);
      chk("rd_adr", s_adr, 32'h1000_0004);
      chk("rd_we", s_we, 0);
      chk("rd_scyc", s_cyc, 1);
      m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("rd_mack", m_ack, 4'b0100);
      chk("rd_mdat", m_dat_o, 32'hDEAD_BEEF);
      chk("rd_drop_scyc", s_cyc, 0);
      tick();
      s_ack = 1'b0;
      chk("rd_idle", grant, 0);
      tick();
      chk("rd_next_m0", grant, 4'b0001);
      chk("rd_m0_noack", m_ack, 0);

      // ---- reset in the middle of a master3 write ----
      m_cyc = '0; m_stb = '0;
      tick();
      m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b1000;
      m_dat[3*32 +: 32] = 32'hA5A5_0F0F;
      tick();
      chk("wr_grant3", grant, 4'b1000);
      chk("wr_scyc", s_cyc, 1);
      chk("wr_dat", s_dat_o, 32'hA5A5_0F0F);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_scyc", s_cyc, 0);
      chk("arst_grant", grant, 0);
      m_cyc = 4'b1001; m_stb = 4'b1001;
      @(posedge clk);
      #3;
      rstn = 1'b1;
      #1;
      chk("arst_no_resume", s_cyc, 0);
      tick();
      chk("arst_m0_wins", grant, 4'b0001);
      m_cyc = '0; m_stb = '0; m_we = '0;
      tick();
      tick();

      // ---- stalled slave ----
      m_cyc = 4'b0010; m_stb = 4'b0010;
      tick();
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("stall%0d_err", i), m_err, 0);
         chk($sformatf("stall%0d_scyc", i), s_cyc, 1);
         tick();
      end
      chk("tmo_err", m_err, 4'b0010);
      chk("tmo_scyc", s_cyc, 0);
      chk("tmo_grant", grant, 4'b0010);
      tick();
      chk("tmo_err_once", m_err, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rel%0d_grant", i), grant, 4'b0010);
         chk($sformatf("rel%0d_scyc", i), s_cyc, 0);
         tick();
      end
      m_cyc = '0; m_stb = '0;
      tick();
      chk("rel_done", grant, 0);
`else
      for (int i = 0; i < 1000; i++) begin
         chk("hold_err", m_err, 0);
         chk("hold_grant", grant, 4'b0010);
         tick();
      end
      m_cyc = '0; m_stb = '0;
      tick();
      chk("hold_done", grant, 0);
`endif

      // ---- randomized traffic against the reference model ----
      do_reset();
      owner = -1; last = N-1; since = 0;
      for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
         @(posedge clk);
         acked_m = (owner >= 0 && s_ack && m_cyc[owner]) ? owner : -1;
         if (owner < 0) begin
            owner = next_owner(last, m_cyc);
         end else if (!m_cyc[owner]) begin
            last = owner;
            owner = -1;
         end
         #1;
         for (int m = 0; m < N; m++) begin
            if (!m_cyc[m]) begin
               if ($urandom_range(3) == 0) begin
                  m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = 1'($urandom);
                  m_adr[m*32 +: 32] = $urandom; m_dat[m*32 +: 32] = $urandom;
                  m_sel[m*4 +: 4] = 4'($urandom);
               end
            end else if (m == acked_m) begin
               if ($urandom_range(1) == 0) begin
                  m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
               end else begin
                  m_adr[m*32 +: 32] = $urandom; m_dat[m*32 +: 32] = $urandom;
               end
            end else if (m == owner && $urandom_range(15) == 0) begin
               m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
            end
         end
         s_ack = (since >= 3) || ($urandom_range(1) == 0);
         s_err = !s_ack && ($urandom_range(7) == 0);
         since = (s_ack || s_err) ? 0 : since + 1;
         s_dat_i = $urandom;
         #1;
         chk("rnd_grant", grant, (owner >= 0) ? (64'd1 << owner) : 64'd0);
         chk("rnd_scyc", s_cyc, (owner >= 0) && m_cyc[owner]);
         chk("rnd_mack", m_ack, (owner >= 0 && s_ack) ? (64'd1 << owner) : 64'd0);
         chk("rnd_merr", m_err, (owner >= 0 && s_err) ? (64'd1 << owner) : 64'd0);
         chk("rnd_mdat", m_dat_o, s_dat_i);
         if (owner >= 0 && m_cyc[owner]) begin
            exp_w = m_adr[owner*32 +: 32];
            chk("rnd_adr", s_adr, exp_w);
            exp_w = m_dat[owner*32 +: 32];
            chk("rnd_dat", s_dat_o, exp_w);
            chk("rnd_we", s_we, m_we[owner]);
            chk("rnd_sel", s_sel, m_sel[owner*4 +: 4]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
